// File: rtl/pic_init_sequencer.sv
// pic_init_sequencer: 8259-style ICW1..ICW4 initialization sequencer with OCW decode.
//   clk, rst             clock and asynchronous active-high reset
//   wr_en, a0, din       one-cycle bus write with address bit A0 and data
//   sp_en                SP/EN pin level (1 = master) used when not buffered
//   icw1_q..icw4_q       latched initialization words
//   imr_q                interrupt mask register (OCW1)
//   ocw2_wr, ocw3_wr     registered one-cycle pulses on OCW2/OCW3 writes
//   ocw_data             data of the last OCW2/OCW3 write
//   state_q, init_done   sequencer state and READY indication
//   vec_base, is_master, slave_id  decoded configuration fields
//   seq_err              sticky illegal-write flag, cleared by ICW1
module pic_init_sequencer #(
    parameter int DATA_W    = 8,
    parameter int ID_W      = 3,
    parameter int AUTO_ICW4 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              a0,
    input  logic [DATA_W-1:0] din,
    input  logic              sp_en,
    output logic [DATA_W-1:0] icw1_q,
    output logic [DATA_W-1:0] icw2_q,
    output logic [DATA_W-1:0] icw3_q,
    output logic [DATA_W-1:0] icw4_q,
    output logic [DATA_W-1:0] imr_q,
    output logic              init_done,
    output logic [2:0]        state_q,
    output logic              ocw2_wr,
    output logic              ocw3_wr,
    output logic [DATA_W-1:0] ocw_data,
    output logic [DATA_W-4:0] vec_base,
    output logic              is_master,
    output logic [ID_W-1:0]   slave_id,
    output logic              seq_err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] W_ICW2 = 3'd1;
    localparam logic [2:0] W_ICW3 = 3'd2;
    localparam logic [2:0] W_ICW4 = 3'd3;
    localparam logic [2:0] READY  = 3'd4;
    // Value ICW4 takes when the sequence completes without an ICW4 write.
    localparam logic [DATA_W-1:0] ICW4_DFLT = (AUTO_ICW4 != 0) ? DATA_W'(1) : '0;
    logic [2:0]        state_d;
    logic [DATA_W-1:0] icw1_d, icw2_d, icw3_d, icw4_d, imr_d, ocw_data_d;
    logic              ocw2_d, ocw3_d, seq_err_d;
    logic              is_icw1;
    assign is_icw1 = wr_en & ~a0 & din[4];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            icw1_q   <= '0;
            icw2_q   <= '0;
            icw3_q   <= '0;
            icw4_q   <= '0;
            imr_q    <= '0;
            ocw_data <= '0;
            ocw2_wr  <= 1'b0;
            ocw3_wr  <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            icw1_q   <= icw1_d;
            icw2_q   <= icw2_d;
            icw3_q   <= icw3_d;
            icw4_q   <= icw4_d;
            imr_q    <= imr_d;
            ocw_data <= ocw_data_d;
            ocw2_wr  <= ocw2_d;
            ocw3_wr  <= ocw3_d;
            seq_err  <= seq_err_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        icw1_d     = icw1_q;
        icw2_d     = icw2_q;
        icw3_d     = icw3_q;
        icw4_d     = icw4_q;
        imr_d      = imr_q;
        ocw_data_d = ocw_data;
        ocw2_d     = 1'b0;
        ocw3_d     = 1'b0;
        seq_err_d  = seq_err;
        if (is_icw1) begin
            // ICW1 restarts initialization from any state.
            icw1_d    = din;
            icw2_d    = '0;
            icw3_d    = '0;
            icw4_d    = '0;
            imr_d     = '0;
            seq_err_d = 1'b0;
            state_d   = W_ICW2;
        end else if (state_q > READY) begin
            state_d = IDLE;
        end else if (wr_en) begin
            // Past this point an a0=0 write is known to have din[4]=0.
            case (state_q)
                W_ICW2: begin
                    if (a0) begin
                        icw2_d  = din;
                        state_d = !icw1_q[1] ? W_ICW3 : icw1_q[0] ? W_ICW4 : READY;
                        if (icw1_q[1] && !icw1_q[0]) icw4_d = ICW4_DFLT;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                W_ICW3: begin
                    if (a0) begin
                        icw3_d  = din;
                        state_d = icw1_q[0] ? W_ICW4 : READY;
                        if (!icw1_q[0]) icw4_d = ICW4_DFLT;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                W_ICW4: begin
                    if (a0) begin
                        icw4_d  = din;
                        state_d = READY;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                READY: begin
                    if (a0) begin
                        imr_d = din;
                    end else begin
                        ocw_data_d = din;
                        ocw2_d     = ~din[3];
                        ocw3_d     = din[3];
                    end
                end
                default: seq_err_d = 1'b1;
            endcase
        end
    end
    always_comb begin
        init_done = (state_q == READY);
        vec_base  = icw2_q[DATA_W-1:3];
        is_master = icw4_q[3] ? icw4_q[2] : sp_en;
        slave_id  = icw3_q[ID_W-1:0];
    end
endmodule

// File: tb/tb_pic_init_sequencer.sv
// tb_pic_init_sequencer: random and directed checks against a queue-based model.
module tb_pic_init_sequencer;
    localparam int AUTO = 0;
    logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, a0 = 1'b0, sp_en = 1'b1;
    logic [7:0] din = '0;
    logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q, imr_q, ocw_data;
    logic [4:0] vec_base;
    logic [2:0] state_q, slave_id;
    logic       init_done, ocw2_wr, ocw3_wr, is_master, seq_err;
    logic       sp_next = 1'b1;
    pic_init_sequencer #(.DATA_W(8), .ID_W(3), .AUTO_ICW4(AUTO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .a0(a0), .din(din), .sp_en(sp_en),
        .icw1_q(icw1_q), .icw2_q(icw2_q), .icw3_q(icw3_q), .icw4_q(icw4_q),
        .imr_q(imr_q), .init_done(init_done), .state_q(state_q),
        .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr), .ocw_data(ocw_data),
        .vec_base(vec_base), .is_master(is_master), .slave_id(slave_id),
        .seq_err(seq_err)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    logic [7:0] m_icw [1:4];
    logic [7:0] m_imr, m_ocw;
    bit m_ocw2, m_ocw3, m_err, m_init, chk_on = 1'b0;
    int pend[$];
    function automatic void chk(string n, logic [31:0] g, logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, g, e, $time);
        end
    endfunction
    function automatic void m_reset();
        for (int i = 1; i <= 4; i++) m_icw[i] = '0;
        m_imr = '0; m_ocw = '0; m_ocw2 = 0; m_ocw3 = 0; m_err = 0; m_init = 0;
        pend.delete();
    endfunction
    // State is derived from which ICW is awaited next, not from an encoding.
    function automatic int m_state();
        if (!m_init) return 0;
        if (pend.size() != 0) return pend[0] - 1;
        return 4;
    endfunction
    function automatic void step(bit w, bit a, logic [7:0] d);
        int idx;
        m_ocw2 = 0;
        m_ocw3 = 0;
        if (!w) return;
        if (!a && d[4]) begin
            m_icw[1] = d; m_icw[2] = '0; m_icw[3] = '0; m_icw[4] = '0;
            m_imr = '0; m_err = 0; m_init = 1;
            pend.delete();
            pend.push_back(2);
            if (!d[1]) pend.push_back(3);
            if (d[0]) pend.push_back(4);
        end else if (!m_init) begin
            m_err = 1;
        end else if (pend.size() != 0) begin
            if (a) begin
                idx = pend.pop_front();
                m_icw[idx] = d;
                if (pend.size() == 0 && !m_icw[1][0]) m_icw[4] = (AUTO != 0) ? 8'h01 : 8'h00;
            end else begin
                m_err = 1;
            end
        end else if (a) begin
            m_imr = d;
        end else begin
            m_ocw = d;
            if (d[3]) m_ocw3 = 1; else m_ocw2 = 1;
        end
    endfunction
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("state", 32'(state_q), 32'(m_state()));
            chk("init_done", 32'(init_done), 32'(m_state() == 4));
            chk("icw1", 32'(icw1_q), 32'(m_icw[1]));
            chk("icw2", 32'(icw2_q), 32'(m_icw[2]));
            chk("icw3", 32'(icw3_q), 32'(m_icw[3]));
            chk("icw4", 32'(icw4_q), 32'(m_icw[4]));
            chk("imr", 32'(imr_q), 32'(m_imr));
            chk("ocw_data", 32'(ocw_data), 32'(m_ocw));
            chk("ocw2_wr", 32'(ocw2_wr), 32'(m_ocw2));
            chk("ocw3_wr", 32'(ocw3_wr), 32'(m_ocw3));
            chk("seq_err", 32'(seq_err), 32'(m_err));
            chk("vec_base", 32'(vec_base), 32'(m_icw[2]) / 8);
            chk("is_master", 32'(is_master), 32'(m_icw[4][3] ? m_icw[4][2] : sp_en));
            chk("slave_id", 32'(slave_id), 32'(m_icw[3]) % 8);
        end
    end
    task automatic cyc(input bit w, input bit a, input logic [7:0] d);
        #1 wr_en = w; a0 = a; din = d; sp_en = sp_next;
        @(posedge clk);
        step(w, a, d);
        @(negedge clk);
    endtask
    task automatic arst(input bit lit);
        #1 wr_en = 0; rst = 1;
        #1;
        if (lit) begin
            chk("arst_state", 32'(state_q), 0);
            chk("arst_icw1", 32'(icw1_q), 0);
            chk("arst_icw3", 32'(icw3_q), 0);
            chk("arst_done", 32'(init_done), 0);
            chk("arst_err", 32'(seq_err), 0);
        end
        m_reset();
        #1 rst = 0;
        @(posedge clk);
        step(0, 0, 8'h00);
        @(negedge clk);
    endtask
    initial begin
        bit w, a;
        logic [7:0] d;
        int k;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state_q), 0);
        chk("rst_pulse", 32'(ocw2_wr | ocw3_wr), 0);
        rst = 0;
        chk_on = 1;
        cyc(1, 0, 8'h12); chk("single_st1", 32'(state_q), 1);
        cyc(1, 1, 8'h08);
        chk("single_st", 32'(state_q), 4);
        chk("single_vec", 32'(vec_base), 1);
        chk("single_icw4", 32'(icw4_q), 0);
        chk("single_done", 32'(init_done), 1);
        cyc(1, 0, 8'h11); chk("casc_st1", 32'(state_q), 1);
        cyc(1, 1, 8'h20); chk("casc_st2", 32'(state_q), 2);
        cyc(1, 1, 8'h04); chk("casc_st3", 32'(state_q), 3);
        chk("casc_notdone", 32'(init_done), 0);
        cyc(1, 1, 8'h01); chk("casc_st4", 32'(state_q), 4);
        chk("casc_icw3", 32'(icw3_q), 'h04);
        chk("casc_done", 32'(init_done), 1);
        cyc(1, 1, 8'hFB); chk("ocw1_imr", 32'(imr_q), 'hFB);
        cyc(1, 0, 8'h20);
        chk("ocw2_pulse", 32'(ocw2_wr), 1);
        chk("ocw2_data", 32'(ocw_data), 'h20);
        chk("ocw2_no3", 32'(ocw3_wr), 0);
        cyc(0, 0, 8'h00); chk("ocw2_width", 32'(ocw2_wr), 0);
        cyc(1, 0, 8'h0B);
        chk("ocw3_pulse", 32'(ocw3_wr), 1);
        chk("ocw3_data", 32'(ocw_data), 'h0B);
        chk("ocw_ready", 32'(state_q), 4);
        cyc(1, 0, 8'h11); cyc(1, 1, 8'h20); cyc(1, 0, 8'h13);
        chk("restart_st", 32'(state_q), 1);
        chk("restart_icw2", 32'(icw2_q), 0);
        chk("restart_imr", 32'(imr_q), 0);
        chk("restart_icw1", 32'(icw1_q), 'h13);
        cyc(1, 0, 8'h11); cyc(1, 1, 8'h20);
        cyc(1, 0, 8'h20);
        chk("err_st", 32'(state_q), 2);
        chk("err_flag", 32'(seq_err), 1);
        chk("err_icw3", 32'(icw3_q), 0);
        cyc(1, 0, 8'h11);
        chk("err_clear", 32'(seq_err), 0);
        arst(0);
        cyc(1, 1, 8'h55);
        chk("idle_st", 32'(state_q), 0);
        chk("idle_err", 32'(seq_err), 1);
        cyc(1, 0, 8'h11); cyc(1, 1, 8'h20); cyc(1, 1, 8'h04);
        chk("pre_arst_st", 32'(state_q), 3);
        arst(1);
        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 99);
            w = (k < 85);
            d = 8'($urandom);
            if (k < 8) begin a = 0; d = d | 8'h10; end
            else if (k < 60) a = 1;
            else begin a = 0; d = d & 8'hEF; end
            sp_next = 1'($urandom);
            if ($urandom_range(0, 299) == 0) arst(0);
            else cyc(w, a, d);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
